// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and types for the 4-digit 7-segment scanner.
//               All segment/anode encodings are active-low: a 0 lights the
//               segment or enables the digit. Segment bit order is
//               [0]=a, [1]=b, ... [6]=g.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Decimal digit patterns (active-low, [0]=a .. [6]=g).
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;

  // Only segment g lit: shown for any nibble outside 0..9.
  localparam logic [6:0] SEG_DASH = 7'h3F;
  // Every segment dark.
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // No digit enabled.
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_sel_t;

  // One registered display frame: what the pins carry for one clock.
  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] segment;
    logic       dp;
  } disp_out_t;

  localparam disp_out_t DISP_OFF = '{anode: ANODE_OFF, segment: SEG_OFF, dp: 1'b1};

  // Active-low enable for a single digit position.
  function automatic logic [3:0] anode_for(input digit_sel_t sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational BCD nibble to active-low 7-segment decoder.
//               Values 0..9 map to the standard glyphs; 10..15 show a dash so
//               a corrupt counter digit is visible rather than silently wrong.
// Ports       : bcd_i     [3:0] in  - digit value
//               segment_o [6:0] out - active-low segments, [0]=a .. [6]=g
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] segment_o
);

  always_comb begin
    segment_o = SEG_DASH;
    case (bcd_i)
      4'd0:    segment_o = SEG_0;
      4'd1:    segment_o = SEG_1;
      4'd2:    segment_o = SEG_2;
      4'd3:    segment_o = SEG_3;
      4'd4:    segment_o = SEG_4;
      4'd5:    segment_o = SEG_5;
      4'd6:    segment_o = SEG_6;
      4'd7:    segment_o = SEG_7;
      4'd8:    segment_o = SEG_8;
      4'd9:    segment_o = SEG_9;
      default: segment_o = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg7_display_scan
// Description : Time-multiplexes four packed BCD digits onto a common-anode
//               4-digit 7-segment display. Each digit owns a slot of
//               REFRESH_DIV clocks; slots rotate digit0 -> digit3. A lap
//               snapshot can be frozen, one decimal point is lit, leading
//               zeros above the decimal point can be blanked, and non-BCD
//               nibbles show a dash. All outputs are registered.
// Parameters  : REFRESH_DIV   - clocks per digit slot (>= 2)
//               DP_POS        - digit index (0..3) carrying the decimal point
//               BLANK_LEADING - 1 blanks leading zero digits above DP_POS
// Ports       : clock            in  - system clock, rising edge
//               reset            in  - synchronous, active-high
//               digits_i  [15:0] in  - digit3..digit0, digit0 in [3:0]
//               freeze_i         in  - 1 holds the displayed value (lap)
//               blank_all_i      in  - 1 turns every digit off
//               anode_o   [3:0]  out - active-low digit enables
//               segment_o [6:0]  out - active-low segments, [0]=a .. [6]=g
//               dp_o             out - active-low decimal point
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_display_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter int DP_POS        = 2,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] digits_i,
  input  logic        freeze_i,
  input  logic        blank_all_i,
  output logic [3:0]  anode_o,
  output logic [6:0]  segment_o,
  output logic        dp_o
);

  localparam int                 PRESC_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam digit_sel_t         DP_SEL     = 2'(DP_POS);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_q, presc_d;
  digit_sel_t         sel_q,   sel_d;
  logic [15:0]        snap_q,  snap_d;
  logic               live_q;
  disp_out_t          disp_q,  disp_d;

  logic               w_tick;
  logic [3:0]         w_digit;
  logic [6:0]         w_seg;
  logic [3:0]         w_blank_mask;

  // --------------------------------------------------------------------------
  // Slot timing: prescaler wraps every REFRESH_DIV clocks, advancing the digit
  // select. Both run regardless of blank_all so the scan phase is preserved.
  // --------------------------------------------------------------------------
  assign w_tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    sel_d   = sel_q;
    if (w_tick) begin
      presc_d = '0;
      sel_d   = sel_q + 2'd1;
    end
  end

  // Snapshot tracks the counters every unfrozen cycle, so a freeze holds the
  // value captured on the last cycle before it was raised.
  assign snap_d = freeze_i ? snap_q : digits_i;

  // --------------------------------------------------------------------------
  // Leading-zero blanking: walk from the top digit down, keeping a running
  // "everything from here upward is zero" flag. Digits at or below the
  // decimal point are never blanked, so a value of zero still shows "0.00".
  // --------------------------------------------------------------------------
  always_comb begin
    logic run_zero;
    run_zero     = 1'b1;
    w_blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run_zero = run_zero && (snap_q[4*k +: 4] == 4'd0);
      if (BLANK_LEADING && (k > DP_POS)) begin
        w_blank_mask[k] = run_zero;
      end
    end
  end

  assign w_digit = snap_q[{sel_q, 2'b00} +: 4];

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd_i     (w_digit),
    .segment_o (w_seg)
  );

  // --------------------------------------------------------------------------
  // Output frame for the currently selected slot. live_q stays low for the
  // first cycle out of reset because the snapshot still holds its reset value
  // then; showing it would flash a bogus zero before real digits arrive.
  // --------------------------------------------------------------------------
  always_comb begin
    disp_d = DISP_OFF;
    if (live_q && !blank_all_i && !w_blank_mask[sel_q]) begin
      disp_d.anode   = anode_for(sel_q);
      disp_d.segment = w_seg;
      disp_d.dp      = (sel_q != DP_SEL);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      sel_q   <= '0;
      snap_q  <= 16'h0000;
      live_q  <= 1'b0;
      disp_q  <= DISP_OFF;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      snap_q  <= snap_d;
      live_q  <= 1'b1;
      disp_q  <= disp_d;
    end
  end

  assign anode_o   = disp_q.anode;
  assign segment_o = disp_q.segment;
  assign dp_o      = disp_q.dp;

endmodule
`default_nettype wire
